// File: rtl/dds_pkg.sv
// Shared definitions for the DDS coefficient path: default widths, PROM
// latency, the sequencer state encoding and the coefficient PROM contents.
package dds_pkg;

  localparam int DATA_W_DEF = 48;
  localparam int RD_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  // Coefficient word stored at PROM address a: tag, address, inverted address.
  function automatic logic [DATA_W_DEF-1:0] rom_word(input logic [15:0] a);
    return {16'hC0EF, a, ~a};
  endfunction

endpackage

// File: rtl/coef_prom.sv
// Coefficient PROM with a ce-gated address stage followed by oce-gated
// output stages, RD_LAT cycles from address to dout.
module coef_prom
  import dds_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic [ADDR_W-1:0] ad,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] pipe_r [RD_LAT];

  // Read pipeline: stage 0 loads on ce, later stages advance on oce.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_r[i] <= '0;
    end else begin
      if (ce) pipe_r[0] <= DATA_W'(rom_word(16'(ad)));
      else    pipe_r[0] <= pipe_r[0];
      for (int i = 1; i < RD_LAT; i++) begin
        if (oce) pipe_r[i] <= pipe_r[i-1];
        else     pipe_r[i] <= pipe_r[i];
      end
    end
  end

  assign dout = pipe_r[RD_LAT-1];

endmodule

// File: rtl/coef_seq.sv
// Coefficient block sequencer: fetches len_i consecutive PROM words starting
// at base_i and presents them one at a time on a valid/ready handshake.
module coef_seq
  import dds_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              Fg_CLK,
  input  logic              RESETn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              prom_ce_o,
  output logic              prom_oce_o,
  output logic              prom_reset_o,
  output logic [ADDR_W-1:0] prom_ad_o,
  input  logic [DATA_W-1:0] prom_dout_i,
  output logic [DATA_W-1:0] coef_o,
  output logic [ADDR_W-1:0] coef_idx_o,
  output logic              coef_valid_o,
  input  logic              coef_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);

  seq_state_e        state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [ADDR_W-1:0] idx_r, idx_s;
  logic [ADDR_W:0]   remain_r, remain_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [DATA_W-1:0] coef_r, coef_s;
  logic              ce_r, valid_r, busy_r, done_r;

  // Next-state and datapath update; remain_r counts words still to transfer.
  always_comb begin
    state_s  = state_r;
    addr_s   = addr_r;
    idx_s    = idx_r;
    remain_s = remain_r;
    cnt_s    = cnt_r;
    coef_s   = coef_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            state_s = ST_DONE;
          end else begin
            state_s  = ST_ISSUE;
            addr_s   = base_i;
            idx_s    = '0;
            remain_s = len_i;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
        cnt_s   = '0;
      end
      ST_WAIT: begin
        if (cnt_r == CNT_LAST) begin
          coef_s  = prom_dout_i;
          state_s = ST_HOLD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (coef_ready_i) begin
          if (remain_r > REM_ONE) begin
            addr_s   = addr_r + ADR_ONE;
            idx_s    = idx_r + ADR_ONE;
            remain_s = remain_r - REM_ONE;
            state_s  = ST_ISSUE;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs, decoded from the next state.
  always_ff @(posedge Fg_CLK) begin
    if (!RESETn) begin
      state_r  <= ST_IDLE;
      addr_r   <= '0;
      idx_r    <= '0;
      remain_r <= '0;
      cnt_r    <= '0;
      coef_r   <= '0;
      ce_r     <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      addr_r   <= addr_s;
      idx_r    <= idx_s;
      remain_r <= remain_s;
      cnt_r    <= cnt_s;
      coef_r   <= coef_s;
      ce_r     <= (state_s == ST_ISSUE);
      valid_r  <= (state_s == ST_HOLD);
      busy_r   <= (state_s == ST_ISSUE) || (state_s == ST_WAIT) || (state_s == ST_HOLD);
      done_r   <= (state_s == ST_DONE);
    end
  end

  assign prom_ce_o    = ce_r;
  assign prom_oce_o   = RESETn;
  assign prom_reset_o = ~RESETn;
  assign prom_ad_o    = addr_r;
  assign coef_o       = coef_r;
  assign coef_idx_o   = idx_r;
  assign coef_valid_o = valid_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_coef_seq.sv
// Directed bench for coef_seq driving the coef_prom model: table of block
// requests plus hand-written reset and mid-block reset sequences.
module tb_coef_seq;
  import dds_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 48;
  localparam int RD_LAT = 2;

  logic              Fg_CLK_tb = 1'b0;
  logic              RESETn;
  logic              start_i;
  logic [ADDR_W-1:0] base_i;
  logic [ADDR_W:0]   len_i;
  logic              prom_ce_o, prom_oce_o, prom_reset_o;
  logic [ADDR_W-1:0] prom_ad_o;
  logic [DATA_W-1:0] prom_dout_i;
  logic [DATA_W-1:0] coef_o;
  logic [ADDR_W-1:0] coef_idx_o;
  logic              coef_valid_o, coef_ready_i, busy_o, done_o;

  always #5 Fg_CLK_tb = ~Fg_CLK_tb;

  coef_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .Fg_CLK(Fg_CLK_tb), .RESETn(RESETn), .start_i(start_i), .base_i(base_i),
    .len_i(len_i), .prom_ce_o(prom_ce_o), .prom_oce_o(prom_oce_o),
    .prom_reset_o(prom_reset_o), .prom_ad_o(prom_ad_o), .prom_dout_i(prom_dout_i),
    .coef_o(coef_o), .coef_idx_o(coef_idx_o), .coef_valid_o(coef_valid_o),
    .coef_ready_i(coef_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  coef_prom #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) prom (
    .clk(Fg_CLK_tb), .reset(prom_reset_o), .ce(prom_ce_o), .oce(prom_oce_o),
    .ad(prom_ad_o), .dout(prom_dout_i)
  );

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         stall;
    bit         inject;
    int         exp_busy;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [47:0] exp_word(input logic [3:0] a);
    return {16'hC0EF, 12'h000, a, 12'hFFF, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ce"},    64'(prom_ce_o), 64'd0);
    chk({tag, "_oce"},   64'(prom_oce_o), 64'd0);
    chk({tag, "_prst"},  64'(prom_reset_o), 64'd1);
    chk({tag, "_ad"},    64'(prom_ad_o), 64'd0);
    chk({tag, "_coef"},  64'(coef_o), 64'd0);
    chk({tag, "_idx"},   64'(coef_idx_o), 64'd0);
    chk({tag, "_valid"}, 64'(coef_valid_o), 64'd0);
    chk({tag, "_busy"},  64'(busy_o), 64'd0);
    chk({tag, "_done"},  64'(done_o), 64'd0);
  endtask

  // Runs one block; inputs are driven and outputs sampled on the falling edge.
  task automatic run_block(input vec_t v);
    int         cyc = 0;
    int         busy_cnt = 0;
    int         hold_cnt = 0;
    int         n_issue = 0;
    int         n_xfer = 0;
    int         issue_cyc = 0;
    int         done_cyc = -1;
    logic [3:0] ea;
    base_i = v.base;
    len_i = v.len;
    start_i = 1'b1;
    coef_ready_i = 1'b0;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge Fg_CLK_tb);
      cyc++;
      start_i = 1'b0;
      coef_ready_i = 1'b0;
      if (prom_ce_o) begin
        ea = v.base + 4'(n_issue);
        chk("issue_addr", 64'(prom_ad_o), 64'(ea));
        issue_cyc = cyc;
        n_issue++;
      end
      if (busy_o) busy_cnt++;
      if (coef_valid_o) begin
        ea = v.base + 4'(n_xfer);
        hold_cnt++;
        if (hold_cnt == 1) chk("latency", 64'(cyc - issue_cyc), 64'(RD_LAT + 1));
        chk("coef", 64'(coef_o), 64'(exp_word(ea)));
        chk("idx", 64'(coef_idx_o), 64'(n_xfer));
        if (v.inject && n_xfer == 0 && hold_cnt == 1) begin
          start_i = 1'b1;
          base_i = 4'd12;
          len_i = 5'd5;
        end
        if (hold_cnt > v.stall) begin
          coef_ready_i = 1'b1;
          n_xfer++;
          hold_cnt = 0;
        end
      end
      if (done_o) done_cyc = cyc;
    end
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("n_issue", 64'(n_issue), 64'(v.len));
    chk("n_xfer", 64'(n_xfer), 64'(v.len));
    chk("busy_cycles", 64'(busy_cnt), 64'(v.exp_busy));
    chk("done_cycle", 64'(done_cyc), 64'(v.exp_busy + 1));
    @(negedge Fg_CLK_tb);
    coef_ready_i = 1'b0;
    chk("done_pulse", 64'(done_o), 64'd0);
    chk("busy_after", 64'(busy_o), 64'd0);
    chk("valid_after", 64'(coef_valid_o), 64'd0);
  endtask

  initial begin
    int   n;
    int   cyc;
    vec_t v_post;
    vecs[0] = '{4'd0,  5'd4,  0, 1'b0, 16};
    vecs[1] = '{4'd2,  5'd3,  5, 1'b0, 27};
    vecs[2] = '{4'd15, 5'd3,  0, 1'b0, 12};
    vecs[3] = '{4'd0,  5'd0,  0, 1'b0, 0};
    vecs[4] = '{4'd7,  5'd2,  1, 1'b1, 10};
    vecs[5] = '{4'd3,  5'd16, 0, 1'b0, 64};
    vecs[6] = '{4'd15, 5'd1,  0, 1'b0, 4};
    v_post  = '{4'd5,  5'd2,  0, 1'b0, 8};

    // Reset with a start request pending: it must not be taken.
    RESETn = 1'b0;
    start_i = 1'b1;
    base_i = 4'd3;
    len_i = 5'd4;
    coef_ready_i = 1'b0;
    repeat (3) @(negedge Fg_CLK_tb);
    chk_reset_outputs("rst");
    start_i = 1'b0;
    RESETn = 1'b1;
    @(negedge Fg_CLK_tb);
    chk("rel_oce", 64'(prom_oce_o), 64'd1);
    chk("rel_prst", 64'(prom_reset_o), 64'd0);
    chk("rel_busy", 64'(busy_o), 64'd0);

    for (int k = 0; k < 7; k++) run_block(vecs[k]);

    // Mid-block reset during the wait for the second word.
    base_i = 4'd0;
    len_i = 5'd4;
    start_i = 1'b1;
    coef_ready_i = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 2 && cyc < 100) begin
      @(negedge Fg_CLK_tb);
      start_i = 1'b0;
      cyc++;
      if (prom_ce_o) n++;
    end
    chk("mb_second_issue", 64'(n), 64'd2);
    @(negedge Fg_CLK_tb);
    chk("mb_wait_ce", 64'(prom_ce_o), 64'd0);
    chk("mb_wait_busy", 64'(busy_o), 64'd1);
    RESETn = 1'b0;
    @(negedge Fg_CLK_tb);
    chk_reset_outputs("mbrst");
    RESETn = 1'b1;
    coef_ready_i = 1'b0;
    repeat (2) begin
      @(negedge Fg_CLK_tb);
      chk("mb_idle_valid", 64'(coef_valid_o), 64'd0);
      chk("mb_idle_busy", 64'(busy_o), 64'd0);
    end
    run_block(v_post);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
